// File: rtl/onehot_scan_decoder_if.sv
// Control/status bundle for onehot_scan_decoder: scan controls in, one-hot select and index out.
interface onehot_scan_decoder_if #(
    parameter int N_OUT   = 16,
    parameter int DWELL_W = 16
);
    localparam int SEL_W = $clog2(N_OUT);

    logic               en;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   sel;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [N_OUT-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    modport master (output en, mode, sel, load, dwell, input out, idx, wrap);
    modport slave  (input en, mode, sel, load, dwell, output out, idx, wrap);
endinterface

// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder with static / up / down / ping-pong auto-scan and dwell timer.
// Define ONEHOT_SCAN_ACTIVE_LOW_EN for one-cold outputs (common-anode drive).
module onehot_scan_decoder #(
    parameter int N_OUT   = 16,
    parameter int DWELL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_scan_decoder_if.slave  bus
);
    localparam int SEL_W = $clog2(N_OUT);

`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    localparam logic [N_OUT-1:0] OUT_IDLE   = {N_OUT{ACTIVE_LOW}};
    localparam logic [N_OUT-1:0] ONE        = {{(N_OUT-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0] IDX_MAX    = SEL_W'(N_OUT - 1);
    localparam logic [SEL_W-1:0] IDX_MAX_M1 = SEL_W'(N_OUT - 2);

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_UP     = 2'b01,
        MODE_DOWN   = 2'b10,
        MODE_PING   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    mode_e              mode_s;
    mode_e              mode_r;
    dir_e               dir_r;
    dir_e               dir_n;
    logic [SEL_W-1:0]   idx_r;
    logic [SEL_W-1:0]   idx_n;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_n;
    logic [N_OUT-1:0]   out_r;
    logic [N_OUT-1:0]   out_n;
    logic               wrap_r;
    logic               wrap_n;
    logic               idx_ok_s;
    logic               sel_ok_s;
    logic               mode_chg_s;
    logic               step_s;

    assign mode_s     = mode_e'(bus.mode);
    assign mode_chg_s = (mode_s != mode_r);

    // Range checks collapse to constants when N_OUT fills the code space
    if (N_OUT == (1 << SEL_W)) begin : g_full
        assign idx_ok_s = 1'b1;
        assign sel_ok_s = 1'b1;
    end else begin : g_part
        localparam logic [SEL_W:0] N_LIM = (SEL_W+1)'(N_OUT);
        assign idx_ok_s = ({1'b0, idx_r}   < N_LIM);
        assign sel_ok_s = ({1'b0, bus.sel} < N_LIM);
    end

    // Next-state: load, freeze, mode change, dwell timing, then the scan step itself
    always_comb begin
        idx_n  = idx_r;
        cnt_n  = cnt_r;
        dir_n  = dir_r;
        wrap_n = 1'b0;
        step_s = 1'b0;

        if (bus.load && (sel_ok_s || (mode_s == MODE_STATIC))) begin
            idx_n = bus.sel;
            cnt_n = {DWELL_W{1'b0}};
            if (bus.en && mode_chg_s && (mode_s == MODE_PING)) begin
                dir_n = DIR_UP;
            end else begin
                dir_n = dir_r;
            end
        end else if (!bus.en) begin
            cnt_n = cnt_r;
        end else if (mode_chg_s) begin
            cnt_n = {DWELL_W{1'b0}};
            if (mode_s == MODE_PING) begin
                dir_n = DIR_UP;
            end else begin
                dir_n = dir_r;
            end
        end else if (mode_s == MODE_STATIC) begin
            cnt_n = {DWELL_W{1'b0}};
        end else if (cnt_r >= bus.dwell) begin
            // ">=" also covers dwell shrinking below the running count
            cnt_n  = {DWELL_W{1'b0}};
            step_s = 1'b1;
        end else begin
            cnt_n = cnt_r + DWELL_W'(1);
        end

        if (step_s) begin
            if (!idx_ok_s) begin
                idx_n = {SEL_W{1'b0}};
            end else begin
                case (mode_s)
                    MODE_UP: begin
                        if (idx_r == IDX_MAX) begin
                            idx_n  = {SEL_W{1'b0}};
                            wrap_n = 1'b1;
                        end else begin
                            idx_n = idx_r + SEL_W'(1);
                        end
                    end
                    MODE_DOWN: begin
                        if (idx_r == {SEL_W{1'b0}}) begin
                            idx_n  = IDX_MAX;
                            wrap_n = 1'b1;
                        end else begin
                            idx_n = idx_r - SEL_W'(1);
                        end
                    end
                    MODE_PING: begin
                        if (dir_r == DIR_UP) begin
                            if (idx_r == IDX_MAX) begin
                                idx_n  = IDX_MAX_M1;
                                dir_n  = DIR_DOWN;
                                wrap_n = 1'b1;
                            end else begin
                                idx_n = idx_r + SEL_W'(1);
                            end
                        end else begin
                            if (idx_r == {SEL_W{1'b0}}) begin
                                idx_n  = SEL_W'(1);
                                dir_n  = DIR_UP;
                                wrap_n = 1'b1;
                            end else begin
                                idx_n = idx_r - SEL_W'(1);
                            end
                        end
                    end
                    default: begin
                        idx_n = idx_r;
                    end
                endcase
            end
        end else begin
            wrap_n = 1'b0;
        end
    end

    // Output decode from the current index; polarity folded in by XOR with the idle pattern
    always_comb begin
        out_n = {N_OUT{1'b0}};
        if (bus.en && idx_ok_s) begin
            out_n = ONE << idx_r;
        end else begin
            out_n = {N_OUT{1'b0}};
        end
        out_n = out_n ^ OUT_IDLE;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r  <= {SEL_W{1'b0}};
            cnt_r  <= {DWELL_W{1'b0}};
            dir_r  <= DIR_UP;
            mode_r <= MODE_STATIC;
            out_r  <= OUT_IDLE;
            wrap_r <= 1'b0;
        end else begin
            idx_r  <= idx_n;
            cnt_r  <= cnt_n;
            dir_r  <= dir_n;
            mode_r <= mode_s;
            out_r  <= out_n;
            wrap_r <= wrap_n;
        end
    end

    assign bus.out  = out_r;
    assign bus.idx  = idx_r;
    assign bus.wrap = wrap_r;
endmodule
